// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter
// Shares one single-port 64-bit synchronous memory between instruction fetch,
// the data (MEM-stage) port and a boot loader. Data normally wins over fetch,
// but a starvation counter forces a fetch grant after STARVE_LIMIT lost cycles.
// A mode FSM (RUN/LOAD/DRAIN) holds the CPU while the loader owns the memory.

module unified_mem_arbiter #(
  parameter int ADDR_W       = 13,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [63:0]       if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [63:0]       d_addr,
  input  logic [63:0]       d_wdata,
  input  logic [7:0]        d_wstrb,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [63:0]       d_rdata,
  input  logic              ld_mode,
  input  logic              ld_req,
  input  logic [63:0]       ld_addr,
  input  logic [31:0]       ld_wdata,
  output logic              ld_gnt,
  output logic              cpu_hold,
  output logic              mem_en,
  output logic [7:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [63:0]       mem_wdata,
  input  logic [63:0]       mem_rdata
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {ST_RUN, ST_LOAD, ST_DRAIN} mode_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_D} owner_t;

  mode_t            state;
  mode_t            state_next;
  owner_t           owner;
  logic             addr_hi;
  logic [CNT_W-1:0] starve_cnt;

  // Address bits that never reach the memory (byte offset and out-of-range upper bits)
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr[63:ADDR_W+3], if_addr[1:0],
                              d_addr[63:ADDR_W+3], d_addr[2:0],
                              ld_addr[63:ADDR_W+3], ld_addr[1:0]};

  // Mode state register
  always_ff @(posedge clk) begin
    if (reset) state <= ST_RUN;
    else       state <= state_next;
  end

  // Mode transitions: loader takes over on ld_mode, one drain cycle on release
  always_comb begin
    state_next = state;
    case (state)
      ST_RUN:   if (ld_mode)  state_next = ST_LOAD;
      ST_LOAD:  if (!ld_mode) state_next = ST_DRAIN;
      ST_DRAIN: state_next = ST_RUN;
      default:  state_next = ST_RUN;
    endcase
  end

  // Grant generation: one winner per cycle, nothing while reset or on the RUN->LOAD edge
  always_comb begin
    if_gnt = 1'b0;
    d_gnt  = 1'b0;
    ld_gnt = 1'b0;
    if (!reset) begin
      case (state)
        ST_RUN: begin
          if (!ld_mode) begin
            if (if_req && (starve_cnt == LIMIT)) if_gnt = 1'b1;
            else if (d_req)                      d_gnt  = 1'b1;
            else if (if_req)                     if_gnt = 1'b1;
          end
        end
        ST_LOAD: ld_gnt = ld_req;
        default: ;
      endcase
    end
  end

  // Memory command mux driven by whichever requester won this cycle
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 8'h00;
    mem_addr  = '0;
    mem_wdata = 64'h0;
    if (if_gnt) begin
      mem_en   = 1'b1;
      mem_addr = if_addr[ADDR_W+2:3];
    end else if (d_gnt) begin
      mem_en    = 1'b1;
      mem_addr  = d_addr[ADDR_W+2:3];
      mem_we    = d_we ? d_wstrb : 8'h00;
      mem_wdata = d_we ? d_wdata : 64'h0;
    end else if (ld_gnt) begin
      mem_en    = 1'b1;
      mem_addr  = ld_addr[ADDR_W+2:3];
      mem_we    = ld_addr[2] ? 8'hF0 : 8'h0F;
      mem_wdata = {ld_wdata, ld_wdata};
    end
  end

  // Starvation counter: counts fetch cycles lost to data, frozen outside RUN
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (state == ST_RUN) begin
      if (if_gnt || !if_req)                starve_cnt <= '0;
      else if (d_gnt && starve_cnt != LIMIT) starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // Read owner of the next cycle's memory data, plus the fetch word select
  always_ff @(posedge clk) begin
    if (reset) begin
      owner   <= OWN_NONE;
      addr_hi <= 1'b0;
    end else if (if_gnt) begin
      owner   <= OWN_IF;
      addr_hi <= if_addr[2];
    end else if (d_gnt && !d_we) begin
      owner   <= OWN_D;
    end else begin
      owner   <= OWN_NONE;
    end
  end

  // CPU hold tracks the mode register, so it is registered from the next state
  always_ff @(posedge clk) begin
    if (reset) cpu_hold <= 1'b0;
    else       cpu_hold <= (state_next != ST_RUN);
  end

  assign if_rvalid = (owner == OWN_IF);
  assign d_rvalid  = (owner == OWN_D);
  assign if_rdata  = if_rvalid ? (addr_hi ? mem_rdata[63:32] : mem_rdata[31:0]) : 32'h0;
  assign d_rdata   = d_rvalid ? mem_rdata : 64'h0;

endmodule

// File: doc/unified_mem_arbiter.md
# unified_mem_arbiter

Shares one single-port, 64-bit-wide synchronous memory (1-cycle read latency) between three requesters: the pipeline's instruction fetch port, the pipeline's data (MEM-stage) port and a boot loader port. A per-cycle request/grant handshake drives the `StallF` / `StallM` logic in the datapath. A starvation counter guarantees fetch progress under sustained data traffic. A mode FSM holds the CPU while the loader writes program memory.

## Interface
Parameters:
- `ADDR_W`, 13: doubleword index width; memory depth is 2^ADDR_W x 64 bits.
- `STARVE_LIMIT`, 4: number of consecutive cycles fetch may lose to data before fetch wins.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `if_req`  in  1  fetch request.
- `if_addr`  in  64  fetch byte address.
- `if_gnt`  out  1  fetch granted this cycle (combinational).
- `if_rvalid`  out  1  fetch data valid (registered).
- `if_rdata`  out  32  fetched instruction word.
- `d_req`  in  1  data request.
- `d_we`  in  1  data write (1) / read (0).
- `d_addr`  in  64  data byte address.
- `d_wdata`  in  64  write data, lane-aligned.
- `d_wstrb`  in  8  byte enables for writes.
- `d_gnt`  out  1  data granted this cycle (combinational).
- `d_rvalid`  out  1  data read valid (registered).
- `d_rdata`  out  64  read doubleword.
- `ld_mode`  in  1  loader requests ownership of memory.
- `ld_req`  in  1  loader 32-bit write request.
- `ld_addr`  in  64  loader byte address.
- `ld_wdata`  in  32  loader write word.
- `ld_gnt`  out  1  loader write accepted (combinational).
- `cpu_hold`  out  1  CPU must stall all stages (registered).
- `mem_en`  out  1  memory enable.
- `mem_we`  out  8  memory byte write enables.
- `mem_addr`  out  ADDR_W  doubleword index.
- `mem_wdata`  out  64  memory write data.
- `mem_rdata`  in  64  memory read data, valid one cycle after `mem_en` with `mem_we`=0.

## Operation
- Address mapping: `mem_addr` = `addr[ADDR_W+2:3]`. Upper bits are ignored. `addr[1:0]` is ignored (no misalignment checks).
- At most one grant per cycle. The winner's command drives `mem_*` in the same cycle. With no grant: `mem_en`=0, `mem_we`=0, `mem_addr`/`mem_wdata` = 0.
- Requesters hold `req` and operands stable until they see `gnt`. Non-granted requesters stall.
- Fetch read: `mem_we`=0. The owner register is set to IF and `addr[2]` is latched. Next cycle: `if_rvalid`=1 and `if_rdata` = latched `addr[2]` ? `mem_rdata[63:32]` : `mem_rdata[31:0]`.
- Data read: `mem_we`=0. Owner is set to D. Next cycle: `d_rvalid`=1 and `d_rdata`=`mem_rdata`. Data write: `mem_we`=`d_wstrb`, `mem_wdata`=`d_wdata`, no rvalid.
- Loader write: `mem_wdata`={`ld_wdata`,`ld_wdata`} and `mem_we` = `ld_addr[2]` ? 8'hF0 : 8'h0F.
- When no read is granted, owner is NONE for the next cycle. `rdata` outputs are 0 whenever their rvalid is 0.
- Mode FSM states:
  - RUN: CPU arbitration.
  - LOAD: loader only.
  - DRAIN: no grants.
- FSM transitions:
  - RUN→LOAD when `ld_mode`=1. In that same cycle no CPU grant is issued.
  - LOAD→DRAIN when `ld_mode`=0.
  - DRAIN→RUN unconditionally.
- RUN arbitration: data beats fetch, unless `starve_cnt` == `STARVE_LIMIT`, in which case fetch wins.
- `starve_cnt` (width ceil(log2(STARVE_LIMIT+1))):
  - increments when `if_req`=1 and `d_gnt`=1;
  - clears when `if_gnt`=1 or `if_req`=0;
  - saturates at `STARVE_LIMIT`;
  - holds in LOAD/DRAIN.
- LOAD: `ld_gnt`=`ld_req`. `if_gnt`=`d_gnt`=0. `ld_gnt` is 0 in every other state.
- `cpu_hold` = (state != RUN), registered.
- A read issued in the last RUN cycle still returns its rvalid in the following (LOAD) cycle.

## Timing
- Reset values:
  - state RUN, `starve_cnt` 0, owner NONE;
  - `if_rvalid`=`d_rvalid`=0, `if_rdata`=`d_rdata`=0, `cpu_hold`=0;
  - combinational outputs 0 while reset is high.
- Reset mid-read: the in-flight response is discarded, so rvalid is 0 in the cycle after reset.
- Latency: grant in cycle N, read data in cycle N+1. Back-to-back reads are allowed every cycle (full throughput).
- Write-then-read to the same address on consecutive cycles returns the new data (memory is write-first or has no same-cycle conflict, since accesses are serialized).
- `cpu_hold` rises 1 cycle after `ld_mode` rises. It falls 2 cycles after `ld_mode` falls (LOAD→DRAIN→RUN).
- Simultaneous `d_req`+`if_req` with `starve_cnt`<LIMIT: `d_gnt`=1, `if_gnt`=0.

## Test plan
- Reset then idle, all req=0 → all outputs 0, `cpu_hold`=0. Assert `reset` for 1 cycle while a fetch is in flight → no `if_rvalid` the next cycle.
- Fetch alone: `if_addr`=0x1004 with memory[0x200]=0xAAAA_BBBB_CCCC_DDDD → `if_gnt` in the same cycle, `mem_addr`=0x200, next cycle `if_rvalid`=1, `if_rdata`=0xAAAA_BBBB.
- Data write `d_addr`=0x40, `d_wstrb`=0x0F, `d_wdata`=0x1122_3344 followed by a data read of 0x40 → `mem_we`=0x0F, then `d_rvalid` with `d_rdata[31:0]`=0x1122_3344.
- `d_req` and `if_req` held high continuously, `STARVE_LIMIT`=4 → grant pattern D,D,D,D,IF, repeating; `if_gnt` exactly once per 5 cycles.
- `ld_mode` high with `if_req` pending, loader writes 0x0000_0013 to 0x4 → no CPU grants, `cpu_hold`=1 from the next cycle, `mem_we`=0xF0, `mem_wdata`=0x0000_0013_0000_0013.
- `ld_mode` drop → `cpu_hold` stays 1 for 2 cycles, then `if_gnt` resumes on the cycle `cpu_hold`=0.
